pixel_draw_ctrl: RTL
====================

PIXEL_DRAW_CTRL -- requirements
Module: pixel_draw_ctrl

Interface
REQ-001 Parameters SHALL be: XMAX, default 159, last valid column; YMAX, default 119, last valid row.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 NRST  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  draw command present.
REQ-005 cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_op  input  2  00 PLOT, 01 FILL_ROW, 10 CLEAR, 11 reserved.
REQ-007 x, y  input  8 each  pixel coordinates; rgb  input  9  pixel colour.
REQ-008 disp_req  input  1  display read request, highest priority; disp_addr  input  16  read address.
REQ-009 vram_addr  output  16  {row,col}; vram_we  output  1  write strobe; vram_wdata  output  9.
REQ-010 busy  output  1  state != IDLE; done  output  1  one-cycle pulse; err  output  1  sticky.

Function
REQ-011 FSM states SHALL be IDLE, PLOT, FILL; IDLE->PLOT on accepted op 00, IDLE->FILL on accepted op 01/10, back to IDLE in the cycle its last write issues.
REQ-012 Command fields SHALL be latched on acceptance; cmd_valid while busy SHALL be ignored and not accepted.
REQ-013 A write SHALL issue in a cycle where state is PLOT/FILL and disp_req==0; issued write appears on vram_* (vram_we=1) the following cycle (registered port).
REQ-014 If disp_req==1, next cycle SHALL drive vram_addr=disp_addr, vram_we=0; draw stalls, cursor holds; applies in every state including IDLE.
REQ-015 With no disp_req and no write issued, next cycle SHALL drive vram_we=0, vram_addr/vram_wdata hold.
REQ-016 PLOT SHALL write one pixel at {y,x}; accepted cycle N, no stall -> vram_we=1 in N+2, cmd_ready high in N+2.
REQ-017 FILL_ROW SHALL write {y,c} for c = x..XMAX ascending, rgb constant.
REQ-018 CLEAR SHALL write all pixels row-major from (0,0) to (XMAX,YMAX), column wraps XMAX->0 with row+1; (XMAX+1)*(YMAX+1) writes.
REQ-019 done SHALL pulse in the same cycle as the final vram_we=1 of a command.
REQ-020 Op 11 SHALL be accepted, produce no write, set err, pulse done one cycle after acceptance.
REQ-021 Cursor arithmetic is 8-bit; cursor never exceeds XMAX/YMAX during FILL.

Reset
REQ-022 NRST low SHALL force: state IDLE, vram_we=0, vram_addr=0, vram_wdata=0, busy=0, done=0, err=0, cursor 0; cmd_ready=1 after release.
REQ-023 Reset mid-FILL SHALL abort with no further writes and no done pulse.
REQ-024 err SHALL clear only on reset.

Configuration
REQ-025 Macro DRAW_BOUNDS_CHECK_EN defined: PLOT with x>XMAX or y>YMAX, or FILL_ROW with x>XMAX or y>YMAX, SHALL produce no write, set err, pulse done one cycle after acceptance.
REQ-026 Macro undefined: no check; PLOT writes {y,x} as given; FILL_ROW with x>XMAX writes the single pixel {y,x}.

Structure
REQ-027 Package draw_pkg SHALL hold op encoding enum, state enum, ADDR_W=16, RGB_W=9.
REQ-028 Sub-module draw_cursor SHALL hold column/row counters with load, advance-enable, XMAX wrap and last-pixel flag.

Verification
REQ-029 PLOT x=5,y=3,rgb=0x1FF, no disp_req -> one write addr 0x0305 data 0x1FF two cycles after acceptance, done with it.
REQ-030 FILL_ROW x=150,y=10 -> 10 consecutive writes addr 0x0A96..0x0A9F, done on last, cmd_ready next IDLE cycle.
REQ-031 CLEAR rgb=0 with disp_req high every 4th cycle -> exactly 19200 writes, each pixel once, disp_addr on port the cycle after each disp_req, last addr 0x779F.
REQ-032 PLOT x=200,y=0: with DRAW_BOUNDS_CHECK_EN -> no write, err=1, done; without -> write addr 0x00C8.
REQ-033 NRST low during CLEAR after 100 writes -> vram_we=0 from next cycle, no done, err=0, cmd_ready=1 after release.
REQ-034 cmd_valid held during FILL_ROW with second PLOT -> PLOT accepted only after return to IDLE, op 11 -> err=1, no write.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and widths for the pixel draw controller.
package draw_pkg;
  localparam int ADDR_W = 16;
  localparam int RGB_W  = 9;
  localparam int CRD_W  = 8;

  typedef enum logic [1:0] {
    OP_PLOT     = 2'b00,
    OP_FILL_ROW = 2'b01,
    OP_CLEAR    = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLOT = 2'd1,
    ST_FILL = 2'd2
  } state_e;
endpackage

// File: rtl/draw_cursor.sv
// Column/row cursor: load, advance with XMAX->0 column wrap, last-pixel flag.
module draw_cursor
  import draw_pkg::*;
#(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic             clk,
  input  logic             NRST,
  input  logic             i_load,
  input  logic [CRD_W-1:0] i_col0,
  input  logic [CRD_W-1:0] i_row0,
  input  logic             i_adv,
  input  logic             i_row_mode,
  output logic [CRD_W-1:0] o_col,
  output logic [CRD_W-1:0] o_row,
  output logic             o_last
);
  localparam logic [CRD_W-1:0] XM = CRD_W'(XMAX);
  localparam logic [CRD_W-1:0] YM = CRD_W'(YMAX);

  logic [CRD_W-1:0] r_col;
  logic [CRD_W-1:0] r_row;
  logic             w_col_end;

  // ">=" so an out-of-range start column counts as the end of the row.
  assign w_col_end = (r_col >= XM);
  assign o_last    = w_col_end && (i_row_mode || (r_row >= YM));
  assign o_col     = r_col;
  assign o_row     = r_row;

  always_ff @(posedge clk) begin
    if (!NRST) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_load) begin
      r_col <= i_col0;
      r_row <= i_row0;
    end else if (i_adv) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 8'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end
endmodule

// File: rtl/pixel_draw_ctrl.sv
// Pixel draw controller: PLOT / FILL_ROW / CLEAR into VRAM, display reads take priority.
// Optional macro DRAW_BOUNDS_CHECK_EN rejects out-of-range PLOT/FILL_ROW with err.
module pixel_draw_ctrl
  import draw_pkg::*;
#(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic              clk,
  input  logic              NRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CRD_W-1:0]  x,
  input  logic [CRD_W-1:0]  y,
  input  logic [RGB_W-1:0]  rgb,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [RGB_W-1:0]  vram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e            r_state;
  op_e               r_op;
  logic [RGB_W-1:0]  r_rgb;
  logic [ADDR_W-1:0] r_vram_addr;
  logic              r_vram_we;
  logic [RGB_W-1:0]  r_vram_wdata;
  logic              r_done;
  logic              r_err;

  op_e              w_op;
  logic             w_accept;
  logic             w_issue;
  logic             w_adv;
  logic             w_last;
  logic             w_oob;
  logic [CRD_W-1:0] w_col;
  logic [CRD_W-1:0] w_row;
  logic [CRD_W-1:0] w_col0;
  logic [CRD_W-1:0] w_row0;

  assign w_op     = op_e'(cmd_op);
  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_issue  = (r_state != ST_IDLE) && !disp_req;
  assign w_adv    = (r_state == ST_FILL) && !disp_req && !w_last;
  assign w_col0   = (w_op == OP_CLEAR) ? '0 : x;
  assign w_row0   = (w_op == OP_CLEAR) ? '0 : y;

`ifdef DRAW_BOUNDS_CHECK_EN
  assign w_oob = (x > CRD_W'(XMAX)) || (y > CRD_W'(YMAX));
`else
  assign w_oob = 1'b0;
`endif

  draw_cursor #(.XMAX(XMAX), .YMAX(YMAX)) u_cursor (
    .clk        (clk),
    .NRST       (NRST),
    .i_load     (w_accept),
    .i_col0     (w_col0),
    .i_row0     (w_row0),
    .i_adv      (w_adv),
    .i_row_mode (r_op == OP_FILL_ROW),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (!NRST) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_PLOT;
      r_rgb        <= '0;
      r_vram_addr  <= '0;
      r_vram_we    <= 1'b0;
      r_vram_wdata <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Display read owns the port; the draw simply stalls that cycle.
      if (disp_req) begin
        r_vram_addr <= disp_addr;
        r_vram_we   <= 1'b0;
      end else if (w_issue) begin
        r_vram_addr  <= {w_row, w_col};
        r_vram_we    <= 1'b1;
        r_vram_wdata <= r_rgb;
      end else begin
        r_vram_we <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op  <= w_op;
            r_rgb <= rgb;
            if (w_op == OP_RSVD || (w_op != OP_CLEAR && w_oob)) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else if (w_op == OP_PLOT) begin
              r_state <= ST_PLOT;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_PLOT: begin
          if (!disp_req) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (!disp_req && w_last) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign vram_addr  = r_vram_addr;
  assign vram_we    = r_vram_we;
  assign vram_wdata = r_vram_wdata;
  assign done       = r_done;
  assign err        = r_err;
endmodule
